// File: rtl/button_pio_servicer.sv
// Avalon-MM master that services the single-bit button PIO and queues timestamped presses.
// Define BUTTON_SRV_LOCKOUT_EN to build the post-press LOCKOUT holdoff state and its counter.
module button_pio_servicer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TS_W           = 16,
    parameter int LOCKOUT_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            pio_irq,
    input  logic [31:0]     pio_readdata,
    output logic [1:0]      pio_address,
    output logic            pio_chipselect,
    output logic            pio_write_n,
    output logic [31:0]     pio_writedata,
    output logic            evt_valid,
    output logic [TS_W-1:0] evt_ts,
    input  logic            evt_ready,
    output logic [7:0]      drop_cnt,
    output logic            busy
);
    // state    | meaning
    // INIT     | write irq_mask=1 (addr 2)
    // WAIT_IRQ | idle, wait for pio_irq && enable
    // RD_EC    | read edge_capture (addr 3)
    // CHK      | sample edge_capture bit 0, latch timestamp
    // CLR      | write 1 to edge_capture, push event
    // LOCKOUT  | debounce holdoff, irq ignored
    typedef enum logic [2:0] {INIT, WAIT_IRQ, RD_EC, CHK, CLR, LOCKOUT} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    state_t          state, state_nxt;
    logic            started;
    logic [TS_W-1:0] ts_cnt, ts_hold;
    logic [TS_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            push, pop, full;
    logic            readdata_unused;

    assign readdata_unused = ^pio_readdata[31:1];

`ifdef BUTTON_SRV_LOCKOUT_EN
    localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);
    logic [LK_W-1:0] lk_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lk_cnt <= '0;
        else if (state == CLR)
            lk_cnt <= LK_LOAD;
        else if (state == LOCKOUT && lk_cnt != '0)
            lk_cnt <= lk_cnt - LK_W'(1);
    end
`else
    localparam int LOCKOUT_UNUSED = LOCKOUT_CYCLES;
`endif

    // started holds INIT off the bus while reset is asserted and for the first edge after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:     if (started) state_nxt = WAIT_IRQ;
            WAIT_IRQ: if (pio_irq && enable) state_nxt = RD_EC;
            RD_EC:    state_nxt = CHK;
            CHK:      state_nxt = pio_readdata[0] ? CLR : WAIT_IRQ;
`ifdef BUTTON_SRV_LOCKOUT_EN
            CLR:      state_nxt = LOCKOUT;
            LOCKOUT:  if (lk_cnt == '0) state_nxt = WAIT_IRQ;
`else
            CLR:      state_nxt = WAIT_IRQ;
`endif
            default:  state_nxt = WAIT_IRQ;
        endcase
    end

    always_comb begin
        pio_address    = 2'd0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = 32'd0;
        case (state)
            INIT: begin
                if (started) begin
                    pio_address    = 2'd2;
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_writedata  = 32'd1;
                end
            end
            RD_EC: begin
                pio_address    = 2'd3;
                pio_chipselect = 1'b1;
            end
            CHK: pio_address = 2'd3;
            CLR: begin
                pio_address    = 2'd3;
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_writedata  = 32'd1;
            end
            default: ;
        endcase
    end

    assign busy = (state != WAIT_IRQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt  <= '0;
            ts_hold <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (state == CHK && pio_readdata[0])
                ts_hold <= ts_cnt;
        end
    end

    assign evt_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = evt_valid && evt_ready;
    assign push      = (state == CLR);
    assign evt_ts    = mem[rd_ptr[AW-1:0]];

    // A push while full still lands when the head is popped in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push) begin
                if (!full || pop) begin
                    mem[wr_ptr[AW-1:0]] <= ts_hold;
                    wr_ptr <= wr_ptr + PTR_ONE;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end
endmodule
